// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and backend memory signals of mem_arbiter.
// slave: arbiter side. master: requester/backend side.
interface mem_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             i_req;
    logic [WIDTH-1:0] i_addr;
    logic             i_ack;
    logic [WIDTH-1:0] i_rdata;
    logic             i_err;
    logic             d_req;
    logic             d_wr;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_ack;
    logic [WIDTH-1:0] d_rdata;
    logic             d_err;
    logic             mem_en;
    logic             mem_wr;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_done;
    logic             busy;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        input  mem_rdata, mem_done,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        output mem_en, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata,
        output mem_rdata, mem_done,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
        input  mem_en, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for one shared variable-latency memory (fetch + data ports).
// Ports: clk, rst (sync, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

    state_e           state_q, state_d;
    logic             port_q, port_d;
    logic             last_q, last_d;
    logic             wr_q, wr_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] cap_d;
    logic             load;

    logic             i_ack_q, d_ack_q, i_err_q, d_err_q;
    logic             mem_en_q, busy_q;
    logic [WIDTH-1:0] i_rdata_q, d_rdata_q;

    // port/last: 1 = data port, 0 = instruction port
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        last_d  = last_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        cap_d   = '0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Data wins unless it won last time and fetch waits.
                    port_d  = bus.d_req && !(last_q && bus.i_req);
                    last_d  = port_d;
                    addr_d  = port_d ? bus.d_addr : bus.i_addr;
                    wr_d    = port_d && bus.d_wr;
                    wdata_d = port_d ? bus.d_wdata : '0;
                    if (addr_d[0]) begin
                        err_d   = 1'b1;
                        load    = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                if (bus.mem_done) begin
                    cap_d   = wr_q ? '0 : bus.mem_rdata;
                    err_d   = 1'b0;
                    load    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        load    = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            last_q    <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            mem_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            port_q   <= port_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            i_ack_q  <= (state_d == RESP) && !port_d;
            d_ack_q  <= (state_d == RESP) && port_d;
            i_err_q  <= (state_d == RESP) && !port_d && err_d;
            d_err_q  <= (state_d == RESP) && port_d && err_d;
            mem_en_q <= (state_d == ISSUE);
            busy_q   <= (state_d != IDLE);
            if (load && !port_d) begin
                i_rdata_q <= cap_d;
            end
            if (load && port_d) begin
                d_rdata_q <= cap_d;
            end
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_err     = d_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with TIMEOUT = 4.
// Directed vectors push expected acks/accesses; monitors pop and compare.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.WIDTH(16)) bus ();

    mem_arbiter #(.WIDTH(16), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        bit          port;
        bit          err;
        logic [15:0] rdata;
        int          cyc;
    } ack_t;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } mem_t;

    typedef struct {
        bit          port;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          lat;
        logic [15:0] bk;
        bit          err;
        logic [15:0] rdata;
        bit          mem;
        int          alat;
    } vec_t;

    ack_t ack_q[$];
    mem_t mem_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_acks = 0;

    int          bk_lat  = 1;
    logic [15:0] bk_data = 16'h0;
    int          bk_pend = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Backend: done pulse bk_lat cycles after mem_en; bk_lat 0 never answers.
    always @(negedge clk) begin
        bus.mem_done = 1'b0;
        if (bk_pend > 0) begin
            bk_pend--;
            if (bk_pend == 0) begin
                bus.mem_done  = 1'b1;
                bus.mem_rdata = bk_data;
            end
        end
        if (bus.mem_en && bk_lat > 0) bk_pend = bk_lat;
    end

    // Monitor
    always @(negedge clk) begin
        ack_t a;
        mem_t m;
        bit   p;
        if (bus.mem_en) begin
            if (mem_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL mem_en: unexpected access addr %0h cycle %0d",
                         bus.mem_addr, cyc);
            end else begin
                m = mem_q.pop_front();
                chk("mem_cyc", cyc, m.cyc);
                chk("mem_wr", 32'(bus.mem_wr), 32'(m.wr));
                chk("mem_addr", 32'(bus.mem_addr), 32'(m.addr));
                chk("mem_wdata", 32'(bus.mem_wdata), 32'(m.wdata));
            end
        end
        if (bus.i_ack || bus.d_ack) begin
            n_acks++;
            if (ack_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL ack: unexpected i_ack %b d_ack %b cycle %0d",
                         bus.i_ack, bus.d_ack, cyc);
            end else begin
                a = ack_q.pop_front();
                p = bus.d_ack;
                chk("ack_port", 32'(p), 32'(a.port));
                chk("ack_cyc", cyc, a.cyc);
                chk("ack_err", 32'(p ? bus.d_err : bus.i_err), 32'(a.err));
                chk("ack_rdata", 32'(p ? bus.d_rdata : bus.i_rdata),
                    32'(a.rdata));
                chk("other_ack_err",
                    32'(p ? {bus.i_ack, bus.i_err} : {bus.d_ack, bus.d_err}),
                    32'(0));
            end
        end
    end

    task automatic wait_acks(input int target);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (n_acks >= target) return;
        end
        chk("ack_wait_expired", 32'(n_acks), 32'(target));
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_ctl"}, 32'({bus.i_ack, bus.d_ack, bus.i_err, bus.d_err,
                                bus.mem_en, bus.mem_wr, bus.busy}), 32'(0));
        chk({tag, "_maddr"}, 32'(bus.mem_addr), 32'(0));
        chk({tag, "_mwdata"}, 32'(bus.mem_wdata), 32'(0));
        chk({tag, "_irdata"}, 32'(bus.i_rdata), 32'(0));
        chk({tag, "_drdata"}, 32'(bus.d_rdata), 32'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int   c;
        mem_t m;
        ack_t a;
        c = cyc;
        if (v.mem) begin
            m.wr    = v.wr;
            m.addr  = v.addr;
            m.wdata = v.port ? v.wdata : 16'h0;
            m.cyc   = c + 1;
            mem_q.push_back(m);
        end
        a.port  = v.port;
        a.err   = v.err;
        a.rdata = v.rdata;
        a.cyc   = c + v.alat;
        ack_q.push_back(a);
        bk_lat  = v.lat;
        bk_data = v.bk;
        if (v.port) begin
            bus.d_req   = 1'b1;
            bus.d_wr    = v.wr;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        wait_acks(n_acks + 1);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
    endtask

    // port wr addr wdata lat bk err rdata mem ack-latency
    vec_t vecs[9] = '{
        '{0, 0, 16'h0010, 16'h0000, 1, 16'hBEEF, 0, 16'hBEEF, 1, 3},
        '{1, 1, 16'h0100, 16'h1234, 3, 16'hDEAD, 0, 16'h0000, 1, 5},
        '{1, 0, 16'h0101, 16'h0000, 1, 16'h1111, 1, 16'h0000, 0, 1},
        '{0, 0, 16'h0020, 16'h0000, 0, 16'h2222, 1, 16'h0000, 1, 6},
        '{0, 0, 16'h0022, 16'h0000, 2, 16'h5A5A, 0, 16'h5A5A, 1, 4},
        '{1, 0, 16'h0200, 16'h0000, 4, 16'hC3C3, 0, 16'hC3C3, 1, 6},
        '{1, 0, 16'h0202, 16'h0000, 5, 16'h9999, 1, 16'h0000, 1, 6},
        '{0, 0, 16'h0003, 16'h0000, 1, 16'h3333, 1, 16'h0000, 0, 1},
        '{1, 0, 16'h0300, 16'h0000, 1, 16'h4242, 0, 16'h4242, 1, 3}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        bus.i_req     = 1'b0;
        bus.i_addr    = 16'h0;
        bus.d_req     = 1'b0;
        bus.d_wr      = 1'b0;
        bus.d_addr    = 16'h0;
        bus.d_wdata   = 16'h0;
        bus.mem_rdata = 16'h0;
        bus.mem_done  = 1'b0;
        repeat (2) @(posedge clk);
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Contention from reset: D, I, D, I.
        c       = cyc;
        bk_lat  = 1;
        bk_data = 16'h7777;
        mem_q.push_back('{1, 16'h0400, 16'hAAAA, c + 1});
        mem_q.push_back('{0, 16'h0030, 16'h0000, c + 5});
        mem_q.push_back('{1, 16'h0400, 16'hAAAA, c + 9});
        mem_q.push_back('{0, 16'h0030, 16'h0000, c + 13});
        ack_q.push_back('{1, 0, 16'h0000, c + 3});
        ack_q.push_back('{0, 0, 16'h7777, c + 7});
        ack_q.push_back('{1, 0, 16'h0000, c + 11});
        ack_q.push_back('{0, 0, 16'h7777, c + 15});
        bus.d_req   = 1'b1;
        bus.d_wr    = 1'b1;
        bus.d_addr  = 16'h0400;
        bus.d_wdata = 16'hAAAA;
        bus.i_req   = 1'b1;
        bus.i_addr  = 16'h0030;
        wait_acks(n_acks + 4);
        @(posedge clk);
        #1;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        bus.d_wr  = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(vecs[k]);

        // Reset during BUSY; the late done must not produce an ack.
        c       = cyc;
        bk_lat  = 3;
        bk_data = 16'h6666;
        mem_q.push_back('{0, 16'h0040, 16'h0000, c + 1});
        bus.i_req  = 1'b1;
        bus.i_addr = 16'h0040;
        repeat (2) @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.i_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("midbusy");
        repeat (3) @(posedge clk);
        check_zero("late_done");
        @(posedge clk);
        #1;
        run_vec(vecs[8]);

        repeat (3) @(posedge clk);
        chk("ack_q_empty", 32'(ack_q.size()), 32'(0));
        chk("mem_q_empty", 32'(mem_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
